// File: rtl/harmonic_phase_sequencer.sv
// rtl/harmonic_phase_sequencer.sv - per-sample harmonic phase walker over the sample-position RAM
module harmonic_phase_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_start,
  input  logic                  clear_req,
  input  logic [DATA_WIDTH-1:0] freq_inc,
  input  logic [ADDR_WIDTH-1:0] harm_limit,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] pos_out,
  output logic [ADDR_WIDTH-1:0] harm_out,
  output logic                  pos_valid,
  input  logic                  pos_ready,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0]   H_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

  state_t r_state;
  state_t w_state_nxt;

  // h carries one extra bit so harm_limit = all-ones still terminates
  logic [ADDR_WIDTH:0]   r_h;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_base_inc;
  // harm_inc carries one extra bit so the Nyquist compare never wraps
  logic [DATA_WIDTH:0]   r_harm_inc;
  logic [ADDR_WIDTH-1:0] r_limit;
  logic [DATA_WIDTH-1:0] r_pos_out;
  logic [ADDR_WIDTH-1:0] r_harm_out;
  logic                  r_pos_valid;
  logic                  r_frame_done;

  logic                  w_slot_free;
  logic                  w_stop;
  logic                  w_start;
  logic                  w_clear_go;
  logic                  w_emit;
  logic                  w_end;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_din;
  logic                  w_ram_we;

  assign w_slot_free = !r_pos_valid || pos_ready;
  assign w_stop      = (r_h > {1'b0, r_limit}) ||
                       (r_harm_inc[DATA_WIDTH:DATA_WIDTH-1] != 2'b00);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and the combinational RAM port
  always_comb begin
    w_state_nxt = r_state;
    w_ram_addr  = r_h[ADDR_WIDTH-1:0];
    w_ram_din   = '0;
    w_ram_we    = 1'b0;
    w_start     = 1'b0;
    w_clear_go  = 1'b0;
    w_emit      = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // clear wins over a coincident start; the start is simply dropped
        if (clear_req) begin
          w_state_nxt = S_CLEAR;
          w_clear_go  = 1'b1;
        end else if (sample_start) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
        end
      end
      S_RUN: begin
        if (w_slot_free) begin
          if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_end       = 1'b1;
          end else begin
            w_ram_we  = 1'b1;
            w_ram_din = ram_dout + r_harm_inc[DATA_WIDTH-1:0];
            w_emit    = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        w_ram_addr = r_cnt;
        w_ram_we   = 1'b1;
        w_ram_din  = '0;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame counters: harmonic index, accumulated increment and latched frame parameters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h        <= '0;
      r_base_inc <= '0;
      r_harm_inc <= '0;
      r_limit    <= '0;
    end else if (w_start) begin
      r_h        <= '0;
      r_base_inc <= freq_inc;
      r_harm_inc <= {1'b0, freq_inc};
      r_limit    <= harm_limit;
    end else if (w_emit) begin
      r_h        <= r_h + H_ONE;
      r_harm_inc <= r_harm_inc + {1'b0, r_base_inc};
    end
  end

  // Clear sweep address counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_clear_go) begin
      r_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Downstream output slot: load on emit, drop once accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos_out   <= '0;
      r_harm_out  <= '0;
      r_pos_valid <= 1'b0;
    end else if (w_emit) begin
      r_pos_out   <= ram_dout;
      r_harm_out  <= r_h[ADDR_WIDTH-1:0];
      r_pos_valid <= 1'b1;
    end else if (r_pos_valid && pos_ready) begin
      r_pos_valid <= 1'b0;
    end
  end

  // One-cycle end-of-frame pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_end;
    end
  end

  assign ram_addr   = w_ram_addr;
  assign ram_din    = w_ram_din;
  assign ram_we     = w_ram_we;
  assign pos_out    = r_pos_out;
  assign harm_out   = r_harm_out;
  assign pos_valid  = r_pos_valid;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/harmonic_phase_sequencer.md
# harmonic_phase_sequencer

Per-sample sequencer that walks the harmonic table once for each output sample. For each harmonic it reads the stored phase position from the sample-position RAM, emits that position to the downstream sine-lookup stage, and writes back the position advanced by that harmonic's phase increment. The frame stops at the harmonic limit or at Nyquist. The block is the sole read/write master of the sample-position RAM, whose read is asynchronous and whose write is synchronous.

## Interface
- ADDR_WIDTH, 8, harmonic index width; the RAM depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 16, phase position and phase increment width.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_start  in  1  one-cycle pulse requesting a new frame.
- clear_req  in  1  level request to zero all positions.
- freq_inc  in  DATA_WIDTH  fundamental phase increment per sample; latched at frame start.
- harm_limit  in  ADDR_WIDTH  highest harmonic index to process, inclusive; latched at frame start.
- ram_addr  out  ADDR_WIDTH  RAM address (combinational).
- ram_din  out  DATA_WIDTH  RAM write data (combinational).
- ram_we  out  1  RAM write enable (combinational).
- ram_dout  in  DATA_WIDTH  RAM asynchronous read data for ram_addr.
- pos_out  out  DATA_WIDTH  pre-update position of the current harmonic (registered).
- harm_out  out  ADDR_WIDTH  harmonic index for pos_out (registered).
- pos_valid  out  1  pos_out/harm_out valid.
- pos_ready  in  1  downstream accepts the current output.
- busy  out  1  high in RUN or CLEAR.
- frame_done  out  1  one-cycle pulse when a frame ends (registered).

## Operation
- States: IDLE, RUN, CLEAR.
- IDLE
  - If clear_req=1: go to CLEAR and clear the counter to 0. clear_req has priority; a coincident sample_start is dropped.
  - Else if sample_start=1: latch base_inc=freq_inc and harm_inc=freq_inc, set h=0, go to RUN.
  - In IDLE, ram_we=0 and ram_addr=h[ADDR_WIDTH-1:0].
- Counter widths: h is ADDR_WIDTH+1 bits; harm_inc is DATA_WIDTH+1 bits.
- RUN
  - slot_free = !pos_valid || pos_ready.
  - If slot_free=0: stall. ram_we=0 and all state is held.
  - If slot_free=1 and (h > harm_limit_latched or harm_inc >= 2^(DATA_WIDTH-1)):
    - no write;
    - go to IDLE;
    - frame_done<=1 for the next cycle.
  - Else (slot_free=1, no stop condition):
    - ram_addr=h, ram_we=1;
    - ram_din=(ram_dout+harm_inc[DATA_WIDTH-1:0]) mod 2^DATA_WIDTH;
    - pos_out<=ram_dout, harm_out<=h, pos_valid<=1;
    - h<=h+1, harm_inc<=harm_inc+base_inc.
- pos_valid clears when pos_valid&&pos_ready and no new output is produced in that cycle.
- CLEAR
  - Each cycle writes ram_we=1, ram_din=0, ram_addr=counter, then increments the counter.
  - After address 2^ADDR_WIDTH-1 is written, go to IDLE.
  - No pos_valid and no frame_done are produced.
- sample_start in RUN or CLEAR is ignored. clear_req in RUN or CLEAR is acted on only if it is still high once the block is back in IDLE.
- freq_inc=0 processes harmonics 0..harm_limit and rewrites unchanged positions.
- freq_inc >= 2^(DATA_WIDTH-1) produces an empty frame: no writes, frame_done only.
- harm_limit=2^ADDR_WIDTH-1 terminates correctly because h has an extra bit.

## Timing
- Reset (reset_n=0), immediate and asynchronous:
  - state=IDLE;
  - h, counter, base_inc, harm_inc = 0;
  - pos_out=0, harm_out=0, pos_valid=0, frame_done=0;
  - busy=0, ram_we=0.
- Reset does not touch RAM contents. Reset mid-frame aborts with no further writes; already-updated harmonics keep their new values.
- Frame timing, with sample_start in cycle 0 and pos_ready held high:
  - RUN begins in cycle 1.
  - Harmonic k is written in cycle 1+k; pos_valid for harmonic k is high in cycle 2+k.
  - For K processed harmonics, the stop check is in cycle K+1 and frame_done=1 in cycle K+2.
  - busy=1 in cycles 1..K+1.
- Throughput: one harmonic per cycle with no stalls.
- A stall adds exactly one cycle per cycle of pos_valid&&!pos_ready.
- CLEAR takes exactly 2^ADDR_WIDTH cycles.

## Test plan
- Reset: assert reset_n=0 mid-frame -> all registered outputs 0, ram_we=0, busy=0 immediately; RAM entries already written keep their values.
- Clear: clear_req pulse with RAM preloaded to 0xAAAA -> 256 consecutive writes of 0 to addresses 0..255, busy high 256 cycles, then IDLE; RAM reads all 0.
- Nyquist stop: RAM zeroed, freq_inc=0x1000, harm_limit=255, pos_ready=1.
  - Frame 1: 7 writes (0x1000..0x7000 to h0..6), pos_out all 0, frame_done in cycle 9.
  - Frame 2: pos_out 0x1000..0x7000; h6 written 0xE000.
- Harmonic limit: freq_inc=0x0100, harm_limit=2 -> exactly 3 writes (0x0100, 0x0200, 0x0300), harm_out 0,1,2, frame_done in cycle 5.
- Backpressure: pos_ready=0 for 5 cycles after the first pos_valid -> ram_we=0, pos_out/harm_out held for those cycles; the sequence then resumes with no lost or duplicated harmonic.
- Wrap and empty frame:
  - h0 preloaded 0xFF00, freq_inc=0x0200, harm_limit=0 -> 0x0100 written.
  - freq_inc=0x8000 -> no writes, frame_done in cycle 2.
